// File: rtl/imem_loader.sv
// Boot-time image loader. Packs a byte stream into little-endian words, writes them
// into the instruction SRAM, and holds the core in reset until the image is in place.
module imem_loader #(
    parameter int AWIDTH = 10,
    parameter int SIZE   = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    input  logic [7:0]        IN_DATA,
    input  logic              IN_LAST,
    output logic              IN_READY,
    output logic              MEM_CSN,
    output logic              MEM_WEN,
    output logic [3:0]        MEM_BE,
    output logic [31:0]       MEM_ADDR,
    output logic [31:0]       MEM_DI,
    output logic              CORE_RSTn,
    output logic              DONE,
    output logic              OVERFLOW,
    output logic [AWIDTH:0]   WORD_COUNT
);

    typedef enum logic [1:0] {S_LOAD, S_FINISH, S_DONE, S_ERROR} state_t;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] di;
    } wr_req_t;

    localparam logic [AWIDTH:0] LAST_WORD = (AWIDTH + 1)'(SIZE - 1);

    state_t          state, state_nx;
    logic [1:0]      byte_idx;
    logic [31:0]     buf_q;
    logic [AWIDTH:0] wcnt;
    wr_req_t         wr_q;
    logic            ready_q;
    logic            accept, complete;
    logic [31:0]     word_nx;
    logic [31:0]     wr_addr;

    always_comb begin
        accept   = IN_VALID && ready_q;
        complete = accept && ((byte_idx == 2'd3) || IN_LAST);
        // buffer is cleared after every word, so upper bytes are already zero-padded
        word_nx  = buf_q | ({24'd0, IN_DATA} << {byte_idx, 3'b000});
        wr_addr  = '0;
        wr_addr[AWIDTH+2:2] = wcnt;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_LOAD: begin
                if (complete) begin
                    if (IN_LAST)
                        state_nx = S_FINISH;
                    else if (wcnt == LAST_WORD)
                        state_nx = S_ERROR;
                end
            end
            S_FINISH: state_nx = S_DONE;
            default:  state_nx = state;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= S_LOAD;
        else
            state <= state_nx;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            byte_idx  <= 2'd0;
            buf_q     <= '0;
            wcnt      <= '0;
            wr_q      <= '0;
            MEM_CSN   <= 1'b1;
            MEM_WEN   <= 1'b1;
            ready_q   <= 1'b0;
            DONE      <= 1'b0;
            CORE_RSTn <= 1'b0;
            OVERFLOW  <= 1'b0;
        end else begin
            ready_q   <= (state_nx == S_LOAD);
            // release one edge after entering DONE so the final write is already committed
            DONE      <= (state == S_DONE);
            CORE_RSTn <= (state == S_DONE);
            OVERFLOW  <= OVERFLOW | (state_nx == S_ERROR);
            MEM_CSN   <= !complete;
            MEM_WEN   <= !complete;
            wr_q.be   <= complete ? 4'hF : 4'h0;
            if (complete) begin
                wr_q.addr <= wr_addr;
                wr_q.di   <= word_nx;
                buf_q     <= '0;
                byte_idx  <= 2'd0;
                wcnt      <= wcnt + 1'b1;
            end else if (accept) begin
                buf_q    <= word_nx;
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

    assign IN_READY   = ready_q;
    assign MEM_BE     = wr_q.be;
    assign MEM_ADDR   = wr_q.addr;
    assign MEM_DI     = wr_q.di;
    assign WORD_COUNT = wcnt;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time image loader: the write-side counterpart of the core's instruction fetch port. It accepts a byte stream over a valid/ready handshake and packs it into little-endian 32-bit words. Each word is written into the instruction SP_SRAM through that SRAM's native port (CSN, WEN, BE, ADDR, DI). It holds the RISCV_TOP core in reset until the whole image is written, then releases it. It sits between the bench/host stream source and the I-memory write port. The core's fetch port remains the only reader.

## Interface
Parameters:
- AWIDTH, 10, word-address width of the target SRAM.
- SIZE, 1024, capacity of the target SRAM in words.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  stream byte valid.
- IN_DATA  in  8  stream byte.
- IN_LAST  in  1  qualifies the final byte of the image.
- IN_READY  out  1  loader can accept a byte.
- MEM_CSN  out  1  SRAM chip select, active-low.
- MEM_WEN  out  1  SRAM write enable, active-low (1 = read/idle).
- MEM_BE  out  4  SRAM byte enables, active-high.
- MEM_ADDR  out  32  byte address; SRAM is driven with MEM_ADDR[AWIDTH+1:2].
- MEM_DI  out  32  write data.
- CORE_RSTn  out  1  core reset, active-low; 0 while loading.
- DONE  out  1  image loaded, core released.
- OVERFLOW  out  1  image exceeded SIZE words; sticky until RST.
- WORD_COUNT  out  AWIDTH+1  words written so far.

## Operation
- States: LOAD, FINISH, DONE, ERROR.
- Reset values:
  - State, counters and buffers: state = LOAD, byte index = 0, word address = 0, assembly buffer = 0.
  - Memory port: MEM_CSN = 1, MEM_WEN = 1, MEM_BE = 0, MEM_ADDR = 0, MEM_DI = 0.
  - Status outputs: CORE_RSTn = 0, DONE = 0, OVERFLOW = 0, WORD_COUNT = 0.
  - Handshake: IN_READY = 0 while RST is high.
- IN_READY = 1 only in LOAD.
- A byte is accepted on a rising edge with IN_VALID && IN_READY. Byte index k (0..3) is stored to buffer bits [8k+7:8k]. The index is a 2-bit counter that wraps 3 -> 0.
- Word completes when index 3 is accepted, or when IN_LAST is accepted. On completion:
  - Unreceived upper bytes are zero-padded.
  - The word is moved to the write register.
  - The buffer is cleared.
  - A write is issued with MEM_BE = 4'b1111 and MEM_ADDR = word address << 2.
  - Word address and WORD_COUNT increment.
- The write register is separate from the assembly buffer, so sustained throughput is 1 byte/cycle with no stalls.
- Transitions:
  - LOAD -> FINISH when a completing byte carries IN_LAST.
  - LOAD -> ERROR when word SIZE-1 completes without IN_LAST. Word SIZE-1 is still written; no address >= SIZE is ever written.
  - FINISH -> DONE on the next edge.
  - DONE and ERROR are terminal until RST.
- In DONE: CORE_RSTn = 1, DONE = 1, IN_READY = 0. Further IN_VALID is ignored and no writes occur.
- In ERROR: OVERFLOW = 1, CORE_RSTn stays 0, IN_READY = 0.
- IN_VALID with IN_READY = 0 has no effect. IN_DATA and IN_LAST are don't-care then.

## Timing
- Write latency: accepting edge t completes a word. MEM_CSN = 0, MEM_WEN = 0, MEM_BE, MEM_ADDR and MEM_DI are valid for exactly the cycle following edge t. The SRAM samples them at edge t+1. At all other times MEM_CSN = 1 and MEM_WEN = 1.
- Back-to-back words produce write cycles spaced 4 cycles apart at full rate.
- Release: final byte accepted at edge t gives write cycle t..t+1 and state FINISH. CORE_RSTn and DONE rise after edge t+2, so the last write is committed before the core's first fetch.
- RST assertion mid-load, at any time:
  - All outputs immediately take their reset values.
  - The partial word is discarded and the word address returns to 0.
  - The core is re-held in reset.
- After RST deasserts, IN_READY = 1 from the first rising edge onward.
- All outputs are registered. IN_READY is a decode of registered state only.

## Test plan
- Two full words: bytes 13 00 00 00 93 00 10 00, LAST on the 8th, IN_VALID held high.
  - Writes: addr 0x0 = 0x00000013, then addr 0x4 = 0x00100093, in cycles 4 apart.
  - WORD_COUNT = 2; DONE and CORE_RSTn rise 2 edges after the 8th byte.
- Partial final word: bytes 11 22 33 44 55 66, LAST on 66.
  - Writes: addr 0x0 = 0x44332211, addr 0x4 = 0x00006655, both with BE = 4'b1111.
  - WORD_COUNT = 2.
- Gapped stream: same 8 bytes as the first test, IN_VALID randomly deasserted for 0..5 cycles between bytes.
  - Identical SRAM contents; MEM_CSN low in exactly 2 cycles.
- Overflow, with AWIDTH = 2, SIZE = 4: 20 bytes 00..13, no LAST.
  - Exactly 4 writes, addresses 0x0/0x4/0x8/0xC; last write data = 0x0F0E0D0C.
  - OVERFLOW = 1 and IN_READY = 0 after the 16th byte; no 5th write.
  - CORE_RSTn stays 0.
- Reset mid-load: 3 bytes, then a 1-cycle RST pulse, then AA BB CC DD with LAST.
  - Single write: addr 0x0 = 0xDDCCBBAA; WORD_COUNT = 1; DONE = 1.
- Post-done stimulus: after DONE, hold IN_VALID high for 10 cycles.
  - IN_READY = 0, no MEM_CSN activity, WORD_COUNT unchanged, CORE_RSTn stays 1.
